// File: rtl/seg7_hex_scanner.sv
`timescale 1ns/1ps
// seg7_hex_scanner
//
// Drives an eight-digit common-anode seven-segment display by time
// multiplexing. A 32-bit value is latched on a chip-select strobe and shown as
// eight hex digits. Digit 0 is the rightmost. A prescaler sets how long each
// digit is lit, and optional leading-zero blanking turns off the unused
// high-order digits.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   cs         in   load strobe; i_data is captured on any edge where it is high
//   i_data     in   [31:0] value to display; nibble i is shown on digit i
//   lz_blank   in   blank leading-zero digits (digit 0 is never blanked)
//   o_seg      out  [7:0] active-low segments {dp,g,f,e,d,c,b,a}; dp always off
//   o_sel      out  [7:0] active-low digit enables; bit i enables digit i
//   frame_tick out  one-cycle pulse on the edge where the scan wraps 7 -> 0

module seg7_hex_scanner #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [31:0] i_data,
    input  logic        lz_blank,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        frame_tick
);

    localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

    logic [31:0] data_q,  data_d;
    logic [19:0] presc_q, presc_d;
    logic [2:0]  idx_q,   idx_d;
    logic [7:0]  seg_q,   seg_d;
    logic [7:0]  sel_q,   sel_d;
    logic        ftick_q, ftick_d;

    logic        scan_tick;
    logic [3:0]  nibble;
    logic [2:0]  msd;
    logic        blank;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_comb begin
        scan_tick = (presc_q == DIV_LAST);

        data_d  = cs ? i_data : data_q;
        presc_d = scan_tick ? 20'd0 : presc_q + 20'd1;
        idx_d   = scan_tick ? idx_q + 3'd1 : idx_q;
        ftick_d = scan_tick && (idx_q == 3'd7);

        // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 always shows.
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (data_q[4*i +: 4] != 4'h0) begin
                msd = 3'(i);
            end
        end

        // The output register is loaded from the pre-edge data and index,
        // which gives one cycle of latency from a load or index change to the pins.
        nibble = data_q[{idx_q, 2'b00} +: 4];
        blank  = lz_blank && (idx_q > msd);

        if (blank) begin
            seg_d = 8'hFF;
            sel_d = 8'hFF;
        end else begin
            seg_d = hex_to_seg(nibble);
            sel_d = ~(8'b1 << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= 32'd0;
            presc_q <= 20'd0;
            idx_q   <= 3'd0;
            seg_q   <= 8'hFF;
            sel_q   <= 8'hFF;
            ftick_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            ftick_q <= ftick_d;
        end
    end

    assign o_seg      = seg_q;
    assign o_sel      = sel_q;
    assign frame_tick = ftick_q;

endmodule

// File: doc/seg7_hex_scanner.md
# seg7_hex_scanner

Time-multiplexed driver for the board's eight-digit common-anode seven-segment display. It sits downstream of the CPU top level and consumes a 32-bit debug value, typically the instruction-memory address or a register word, as eight hex nibbles. A chip-select latches the value; a prescaler then scans the digits continuously. Segment and digit-select outputs are registered, active-low pins.

## Interface

Parameters:
- SCAN_DIV, default 50000: clocks per digit (100 MHz gives 2 kHz per digit, 250 Hz per frame). Legal range is 1 to 2^20.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: synchronous, active-high. It is sampled on the rising edge of clk.
- cs, in, 1: load strobe. When high at a clock edge, i_data is captured.
- i_data, in, 32: value to display. Nibble i is shown on digit i, and digit 0 is the rightmost.
- lz_blank, in, 1: when 1, leading-zero digits are blanked. Digit 0 is never blanked.
- o_seg, out, 8: active-low segments in bit order {dp,g,f,e,d,c,b,a}. dp is always 1 (off).
- o_sel, out, 8: active-low digit enables. Bit i enables digit i.
- frame_tick, out, 1: one-cycle high pulse on the cycle in which the scan wraps from digit 7 to digit 0.

## Operation

- Data latch (data_reg, 32 bits):
  - Loads i_data on any clock edge with cs=1.
  - Otherwise it holds its value.
  - It is 0 after reset.
- Prescaler (20 bits):
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - scan_tick is asserted combinationally while the count equals SCAN_DIV-1.
  - With SCAN_DIV=1, scan_tick is permanently high and the scan advances every clock.
- Scan index (3 bits):
  - Increments on scan_tick and wraps from 7 to 0.
  - frame_tick is registered. It is set to 1 on the edge where the index goes from 7 to 0, and is 0 on all other edges.
- Leading-zero blanking:
  - msd is the index of the highest nonzero nibble of data_reg, or 0 if data_reg is 0.
  - When lz_blank=1, digits i > msd are blank.
  - A blank digit gives o_seg=8'hFF and o_sel=8'hFF for its whole slot. The slot length and scan order are unchanged.
- Output register, updated every clock:
  - o_sel = ~(8'b1 << index), unless the current digit is blank.
  - o_seg = hex pattern of data_reg[4*index+3 : 4*index], unless the current digit is blank.
  - Patterns 0..F: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
- Exactly zero or one bit of o_sel is low at any time.

## Timing

- Reset:
  - Reset has priority over cs and scan_tick.
  - Next edge sets prescaler=0, index=0, data_reg=0, o_seg=8'hFF, o_sel=8'hFF, frame_tick=0.
  - Reset asserted mid-scan or mid-load discards the cs capture made on that same edge.
- First display after reset:
  - Edge 1 after reset deasserts: outputs show digit 0 of data_reg (C0/FE when data is 0).
  - The index first advances on the edge where prescaler==SCAN_DIV-1, i.e. after SCAN_DIV edges.
- Load latency:
  - cs sampled at edge k updates data_reg at edge k.
  - Segment outputs reflect the new nibble from edge k+1. Total latency is 1 cycle.
  - Loading does not reset the prescaler or the scan index.
- Index-change latency: an index change at edge k appears on o_sel/o_seg at edge k+1.
- Scan period: each digit is displayed for exactly SCAN_DIV cycles. A full frame is 8*SCAN_DIV cycles.
- cs held high continuously: data_reg tracks i_data every cycle; the scan is unaffected.
- lz_blank may change at any cycle. The change takes effect at the next output-register update.

## Test plan

- Reset, SCAN_DIV=4, data 0:
  - o_seg=FF and o_sel=FF after reset.
  - Cycle 1 after release: o_sel=FE, o_seg=C0.
  - o_sel=FD from cycle 5, FB from cycle 9.
  - frame_tick pulses once per 32 cycles.
- Load 32'h89ABCDEF with cs one cycle, lz_blank=0, SCAN_DIV=4:
  - Over one frame, digits 0..7 show 8E, 86, A1, C6, 83, 88, 90, 80.
  - Each digit lasts 4 cycles.
- Load 32'h0000_00A5 with lz_blank=1:
  - Digit 0 shows 92 and digit 1 shows 88.
  - Digits 2..7 give o_sel=FF and o_seg=FF.
  - Load 0 and digit 0 still shows C0/FE.
- Mid-scan reload:
  - Load 32'h11111111, then load 32'h22222222 while digit 3 is active.
  - o_seg changes from F9 to A4 exactly 1 cycle after the cs edge.
  - o_sel is unchanged and the prescaler phase is preserved.
- Reset mid-frame with cs=1 on the same edge: data_reg=0 and outputs are FF/FF on the next edge. The i_data from that edge is not captured.
- SCAN_DIV=1: the index advances every cycle, o_sel cycles FE, FD, FB, ... 7F, and frame_tick pulses every 8 cycles.
